// File: rtl/ut_rand_req_gen_pkg.sv
// rtl/ut_rand_req_gen_pkg.sv - shared types and constants for the random request generator
package ut_rand_req_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int ERR_CNT_MAX  = 255;
  localparam int ISSUED_CNT_W = 16;

  // Error counter increment that sticks at its ceiling instead of wrapping
  function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
    return (cnt == 8'(ERR_CNT_MAX)) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/ut_tag_fifo.sv
// rtl/ut_tag_fifo.sv - show-ahead FIFO holding the tags of outstanding requests
module ut_tag_fifo
  import ut_rand_req_gen_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;
  logic             do_push;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop on empty is dropped; a push on full goes through only alongside a real pop
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointers, occupancy and storage contents
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ut_rand_req_gen.sv
// rtl/ut_rand_req_gen.sv - turns random words into tagged requests and checks in-order responses
module ut_rand_req_gen
  import ut_rand_req_gen_pkg::*;
#(
  parameter int RAND_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int ALIGN_BITS = 2,
  parameter int NUM_REQ    = 64,
  parameter int MAX_OUT    = 4,
  parameter int TAG_W      = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Start,
  input  logic [RAND_W-1:0]       i_Rand_Data,
  output logic                    o_Rand_Next,
  output logic                    o_Req_Valid,
  input  logic                    i_Req_Ready,
  output logic                    o_Req_Write,
  output logic [ADDR_W-1:0]       o_Req_Addr,
  output logic [DATA_W-1:0]       o_Req_Wdata,
  output logic [TAG_W-1:0]        o_Req_Tag,
  input  logic                    i_Rsp_Valid,
  input  logic [TAG_W-1:0]        i_Rsp_Tag,
  output logic                    o_Busy,
  output logic                    o_Done,
  output logic                    o_Err,
  output logic [ISSUED_CNT_W-1:0] o_Issued_Cnt,
  output logic [7:0]              o_Err_Cnt
);

  localparam logic [ADDR_W-1:0]       ADDR_MASK  = ~ADDR_W'((1 << ALIGN_BITS) - 1);
  localparam logic [ISSUED_CNT_W-1:0] NUM_REQ_C  = ISSUED_CNT_W'(NUM_REQ);
  localparam logic [ISSUED_CNT_W-1:0] LAST_ISSUE = ISSUED_CNT_W'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic                    req_valid_q, req_valid_d;
  logic                    req_write_q, req_write_d;
  logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
  logic [DATA_W-1:0]       req_wdata_q, req_wdata_d;
  logic [TAG_W-1:0]        req_tag_q, req_tag_d;
  logic [TAG_W-1:0]        tag_cnt_q, tag_cnt_d;
  logic [ISSUED_CNT_W-1:0] issued_q, issued_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] fifo_dout;
  logic             accept;
  logic             start_run;
  logic             load;
  logic             rsp_err;
  logic             unused_rand;

  // Only the top bit and the address field of the random word are meaningful
  assign unused_rand = ^i_Rand_Data;

  assign accept    = req_valid_q & i_Req_Ready;
  assign start_run = i_Start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  // FIFO occupancy is the outstanding count, so "full" is the outstanding limit
  assign load      = (state_q == ST_ISSUE) & ~req_valid_q & ~fifo_full & (issued_q < NUM_REQ_C);
  assign rsp_err   = i_Rsp_Valid & (fifo_empty | (fifo_dout != i_Rsp_Tag));

  ut_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .push  (accept),
    .din   (req_tag_q),
    .pop   (i_Rsp_Valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Run sequencing; i_Start only matters while no run is in progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_Start) state_d = ST_ISSUE;
      ST_ISSUE: if (accept && (issued_q == LAST_ISSUE)) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  if (i_Start) state_d = ST_ISSUE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    o_Busy = 1'b0;
    o_Done = 1'b0;
    case (state_q)
      ST_ISSUE, ST_DRAIN: o_Busy = 1'b1;
      ST_DONE:            o_Done = 1'b1;
      default:            ;
    endcase
  end

  // Request load/accept and response bookkeeping; a new run wipes the run counters
  always_comb begin
    req_valid_d = req_valid_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_tag_d   = req_tag_q;
    tag_cnt_d   = tag_cnt_q;
    issued_d    = issued_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    if (start_run) begin
      tag_cnt_d = '0;
      issued_d  = '0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (load) begin
        req_valid_d = 1'b1;
        req_write_d = i_Rand_Data[RAND_W-1];
        req_addr_d  = i_Rand_Data[ADDR_W-1:0] & ADDR_MASK;
        req_wdata_d = DATA_W'(issued_q);
        req_tag_d   = tag_cnt_q;
      end
      if (accept) begin
        req_valid_d = 1'b0;
        issued_d    = issued_q + ISSUED_CNT_W'(1);
        tag_cnt_d   = tag_cnt_q + TAG_W'(1);
      end
      if (rsp_err) begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc(err_cnt_q);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_tag_q   <= '0;
      tag_cnt_q   <= '0;
      issued_q    <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_tag_q   <= req_tag_d;
      tag_cnt_q   <= tag_cnt_d;
      issued_q    <= issued_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_Rand_Next  = accept;
  assign o_Req_Valid  = req_valid_q;
  assign o_Req_Write  = req_write_q;
  assign o_Req_Addr   = req_addr_q;
  assign o_Req_Wdata  = req_wdata_q;
  assign o_Req_Tag    = req_tag_q;
  assign o_Err        = err_q;
  assign o_Err_Cnt    = err_cnt_q;
  assign o_Issued_Cnt = issued_q;

endmodule
